// File: rtl/vend_sequencer.sv
// vend_sequencer: credit-and-dispense controller for the soda vending machine.
// Coins accumulate credit in IDLE. A covered selection pulses a vend output for
// one cycle. Remaining credit, or the whole credit on cancel, is then paid out
// through a handshaked hopper: dimes first, then at most one nickel.
module vend_sequencer #(
  parameter int unsigned PRICE      = 50,
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned CREDIT_W   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                soda,
  input  logic                diet,
  input  logic                cancel,
  input  logic                hopper_ack,
  output logic                give_soda,
  output logic                give_diet,
  output logic                change_dime,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_DISPENSE   = 2'd1;
  localparam logic [1:0] S_PAY_DIME   = 2'd2;
  localparam logic [1:0] S_PAY_NICKEL = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   VAL_N    = (CREDIT_W + 1)'(5);
  localparam logic [CREDIT_W:0]   VAL_D    = (CREDIT_W + 1)'(10);
  localparam logic [CREDIT_W:0]   VAL_Q    = (CREDIT_W + 1)'(25);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                give_soda_q, give_soda_d;
  logic                give_diet_q, give_diet_d;
  logic                change_dime_q, change_dime_d;
  logic                change_nickel_q, change_nickel_d;
  logic                coin_reject_q, coin_reject_d;

  logic                coin_any;
  logic                select_any;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] credit_less_dime;
  logic [CREDIT_W-1:0] credit_less_nickel;

  // Where payout goes next for a given remaining credit: dimes while at least
  // ten cents remain, a single nickel for the last five, otherwise done.
  function automatic logic [1:0] payout_state(input logic [CREDIT_W-1:0] c);
    if (c >= DIME_C) begin
      return S_PAY_DIME;
    end else if (c == NICKEL_C) begin
      return S_PAY_NICKEL;
    end else begin
      return S_IDLE;
    end
  endfunction

  // Coin arithmetic: all coins of one cycle are summed and accepted or rejected
  // together; one extra bit keeps the overflow compare exact.
  always_comb begin
    coin_any           = nickel | dime | quarter;
    select_any         = soda | diet;
    coin_sum           = (nickel  ? VAL_N : '0)
                       + (dime    ? VAL_D : '0)
                       + (quarter ? VAL_Q : '0);
    credit_sum         = {1'b0, credit_q} + coin_sum;
    coin_fits          = (credit_sum <= MAX_C);
    credit_less_dime   = credit_q - DIME_C;
    credit_less_nickel = credit_q - NICKEL_C;
  end

  // Next-state, credit and registered-output logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    give_soda_d   = 1'b0;
    give_diet_d   = 1'b0;
    coin_reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (select_any && (credit_q >= PRICE_C)) begin
          // Soda wins a simultaneous soda+diet press.
          credit_d      = credit_q - PRICE_C;
          state_d       = S_DISPENSE;
          give_soda_d   = soda;
          give_diet_d   = ~soda;
          coin_reject_d = coin_any;
        end else if (cancel && (credit_q != '0)) begin
          state_d       = payout_state(credit_q);
          coin_reject_d = coin_any;
        end else if (coin_any) begin
          if (coin_fits) begin
            credit_d = credit_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_DISPENSE: begin
        state_d       = payout_state(credit_q);
        coin_reject_d = coin_any;
      end
      S_PAY_DIME: begin
        coin_reject_d = coin_any;
        if (hopper_ack) begin
          credit_d = credit_less_dime;
          state_d  = payout_state(credit_less_dime);
        end
      end
      S_PAY_NICKEL: begin
        coin_reject_d = coin_any;
        if (hopper_ack) begin
          credit_d = credit_less_nickel;
          state_d  = payout_state(credit_less_nickel);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Requests follow the next state so they appear the cycle the PAY state
    // is entered and stay level across back-to-back coins of one type.
    change_dime_d   = (state_d == S_PAY_DIME);
    change_nickel_d = (state_d == S_PAY_NICKEL);
  end

  // State and output registers; reset discards any unpaid credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      give_soda_q     <= 1'b0;
      give_diet_q     <= 1'b0;
      change_dime_q   <= 1'b0;
      change_nickel_q <= 1'b0;
      coin_reject_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      give_soda_q     <= give_soda_d;
      give_diet_q     <= give_diet_d;
      change_dime_q   <= change_dime_d;
      change_nickel_q <= change_nickel_d;
      coin_reject_q   <= coin_reject_d;
    end
  end

  assign give_soda     = give_soda_q;
  assign give_diet     = give_diet_q;
  assign change_dime   = change_dime_q;
  assign change_nickel = change_nickel_q;
  assign coin_reject   = coin_reject_q;
  assign credit        = credit_q;
  assign busy          = (state_q != S_IDLE);

endmodule
